// File: rtl/four_bit_rca_rcs.sv
// Four-bit ripple-carry adder with combinational sum/carry/overflow outputs
// and a registered status copy (sum, carry, overflow, zero) behind async reset.
module four_bit_rca_rcs (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout,
    output logic       V,
    output logic [3:0] S_q,
    output logic       Cout_q,
    output logic       V_q,
    output logic       Z_q
);

    logic [4:0] w_c;
    logic [3:0] w_s;

    assign w_c[0] = Cin;

    // One full adder per bit; carry ripples strictly from bit 0 upward.
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
        assign w_s[gi]   = A[gi] ^ B[gi] ^ w_c[gi];
        assign w_c[gi+1] = (A[gi] & B[gi]) | (A[gi] & w_c[gi]) | (B[gi] & w_c[gi]);
    end

    assign S    = w_s;
    assign Cout = w_c[4];
    assign V    = w_c[3] ^ w_c[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q    <= '0;
            Cout_q <= 1'b0;
            V_q    <= 1'b0;
            Z_q    <= 1'b0;
        end else begin
            S_q    <= w_s;
            Cout_q <= w_c[4];
            V_q    <= w_c[3] ^ w_c[4];
            Z_q    <= (w_s == 4'b0000);
        end
    end

endmodule

// File: tb/tb_four_bit_rca_rcs.sv
// Scoreboard bench for four_bit_rca_rcs: stimulus pushes arithmetic-model
// expectations, a monitor pops and compares one entry per rising clock edge.
module tb_four_bit_rca_rcs;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] S;
    logic       Cout;
    logic       V;
    logic [3:0] S_q;
    logic       Cout_q;
    logic       V_q;
    logic       Z_q;

    typedef struct {
        logic [3:0] s;
        logic       cout;
        logic       v;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    four_bit_rca_rcs dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .S      (S),
        .Cout   (Cout),
        .V      (V),
        .S_q    (S_q),
        .Cout_q (Cout_q),
        .V_q    (V_q),
        .Z_q    (Z_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int a, input int b, input int cin);
        exp_t e;
        int   usum;
        int   ssum;
        int   sa;
        int   sb;
        usum   = a + b + cin;
        sa     = (a > 7) ? a - 16 : a;
        sb     = (b > 7) ? b - 16 : b;
        ssum   = sa + sb + cin;
        e.s    = 4'(usum % 16);
        e.cout = (usum >= 16);
        e.v    = (ssum > 7) || (ssum < -8);
        e.z    = ((usum % 16) == 0);
        return e;
    endfunction

    task automatic apply(input int a, input int b, input int cin);
        @(negedge clk);
        A   = 4'(a);
        B   = 4'(b);
        Cin = 1'(cin);
        exp_q.push_back(model(a, b, cin));
    endtask

    // Monitor: each rising edge presents the registered result of the
    // inputs applied at the preceding falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("S",      int'(S),      int'(e.s));
                chk("Cout",   int'(Cout),   int'(e.cout));
                chk("V",      int'(V),      int'(e.v));
                chk("S_q",    int'(S_q),    int'(e.s));
                chk("Cout_q", int'(Cout_q), int'(e.cout));
                chk("V_q",    int'(V_q),    int'(e.v));
                chk("Z_q",    int'(Z_q),    int'(e.z));
            end
        end
    end

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 8) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b1;
        A     = 4'h0;
        B     = 4'h0;
        Cin   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_S_q",    int'(S_q),    0);
        chk("rst_Cout_q", int'(Cout_q), 0);
        chk("rst_V_q",    int'(V_q),    0);
        chk("rst_Z_q",    int'(Z_q),    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed boundary and example vectors.
        apply(4'hF, 4'h0, 1);
        apply(4'h7, 4'h1, 0);
        apply(4'b0011, 4'b0101, 0);
        apply(4'b1101, 4'b1011, 0);
        apply(4'b1000, 4'b1101, 1);
        apply(4'b1100, 4'b0001, 1);

        for (int i = 0; i < 512; i++)
            apply(i % 16, (i / 16) % 16, i / 256);

        for (int i = 0; i < 200; i++)
            apply(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));

        // Load a nonzero status, then assert reset between clock edges.
        apply(4'hF, 4'h0, 1);
        drain();
        @(negedge clk);
        A   = 4'd5;
        B   = 4'd6;
        Cin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        e = model(5, 6, 0);
        chk("mid_rst_S_q",    int'(S_q),    0);
        chk("mid_rst_Cout_q", int'(Cout_q), 0);
        chk("mid_rst_V_q",    int'(V_q),    0);
        chk("mid_rst_Z_q",    int'(Z_q),    0);
        chk("mid_rst_S",      int'(S),      int'(e.s));
        chk("mid_rst_Cout",   int'(Cout),   int'(e.cout));
        chk("mid_rst_V",      int'(V),      int'(e.v));
        A = 4'd9;
        #1;
        e = model(9, 6, 0);
        chk("rst_track_S", int'(S), int'(e.s));
        chk("rst_track_V", int'(V), int'(e.v));
        @(posedge clk);
        #1;
        chk("rst_hold_S_q",    int'(S_q),    0);
        chk("rst_hold_Cout_q", int'(Cout_q), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release must load.
        apply(4'h7, 4'h1, 0);
        apply(4'hF, 4'h0, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/four_bit_rca_rcs.md
FOUR_BIT_RCA_RCS -- requirements
Module: four_bit_RCA_RCS

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 4 bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock for the registered status outputs.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: A  input  4  operand A, unsigned or two's complement.
REQ-006 Port: B  input  4  operand B; for subtraction the caller drives ~B.
REQ-007 Port: Cin  input  1  carry into bit 0; the caller drives 1 for subtraction.
REQ-008 Port: S  output  4  combinational sum bits.
REQ-009 Port: Cout  output  1  combinational carry out of bit 3.
REQ-010 Port: V  output  1  combinational signed overflow.
REQ-011 Port: S_q  output  4  registered copy of S.
REQ-012 Port: Cout_q  output  1  registered copy of Cout.
REQ-013 Port: V_q  output  1  registered copy of V.
REQ-014 Port: Z_q  output  1  registered zero flag, equal to (S == 0).

Function
REQ-015 S and Cout SHALL be computed by a ripple chain of four full adders; stage i takes A[i], B[i] and c[i], and c[0] = Cin.
REQ-016 Each full adder SHALL produce sum = a^b^c and carry = ab | ac | bc.
REQ-017 The ripple chain SHALL use no lookahead or prefix logic.
REQ-018 {Cout,S} SHALL equal A + B + Cin as a 5-bit unsigned result for all 512 input combinations.
REQ-019 V SHALL equal c[3] XOR c[4], i.e. the carry into bit 3 XOR Cout.
REQ-020 S, Cout and V SHALL be purely combinational and settle within the same time step as the inputs, with no clock dependency.
REQ-021 The block SHALL contain no internal subtract mode; subtraction A - B is performed by the caller driving B = ~B_orig and Cin = 1.
REQ-022 For unsigned subtraction, Cout = 1 SHALL mean no borrow (A >= B_orig).
REQ-023 On every rising clk edge with rst_n high, S_q, Cout_q, V_q and Z_q SHALL load S, Cout, V and (S == 4'b0000) respectively.
REQ-024 Registered-output latency SHALL be one clock.
REQ-025 Boundary: 4'hF + 4'h0 with Cin = 1 SHALL give S = 0, Cout = 1, V = 0; Z_q SHALL be 1 after the next edge.
REQ-026 Boundary: 4'h7 + 4'h1 with Cin = 0 SHALL give S = 8, Cout = 0, V = 1.
REQ-027 Inputs with X/Z values are not required to produce defined outputs.

Reset
REQ-028 While rst_n = 0, S_q = 0, Cout_q = 0, V_q = 0 and Z_q = 0, applied immediately without waiting for a clock edge.
REQ-029 The combinational outputs S, Cout and V SHALL be unaffected by rst_n.
REQ-030 On rst_n deassertion, registers SHALL resume loading at the first rising clk edge.
REQ-031 Reset asserted mid-operation SHALL clear the registers asynchronously, overriding a coincident clock edge.

Verification
REQ-032 Unsigned add: A = 0011, B = 0101, Cin = 0 -> S = 8, Cout = 0, V = 1.
REQ-033 Signed add: A = 1101 (-3), B = 1011 (-5), Cin = 0 -> S = 1000 (-8), Cout = 1, V = 0.
REQ-034 Unsigned sub 8 - 2: A = 1000, B = ~0010 = 1101, Cin = 1 -> S = 6, Cout = 1, V = 1.
REQ-035 Signed sub -4 - (-2): A = 1100, B = ~1110 = 0001, Cin = 1 -> S = 1110 (-2), Cout = 0, V = 0.
REQ-036 Zero/register path: A = 1111, B = 0000, Cin = 1, then one clk edge -> S_q = 0, Cout_q = 1, V_q = 0, Z_q = 1.
REQ-037 Reset: assert rst_n = 0 between clock edges -> all registered outputs go to 0 immediately while S, Cout and V still track A, B and Cin.
REQ-038 Exhaustive sweep: all 512 {A, B, Cin} combinations -> {Cout,S} = A + B + Cin and V matches the signed-range check.
